nibble_alu: RTL and testbench
=============================

Name: nibble_alu

Overview:
- Combinational 4-bit (nibble) ALU slice, instantiated by the nibble-loop sequencer that walks a 32-bit word one nibble per clock.
- Chaining is done by the caller, which feeds carry_out of one nibble back as carry_in of the next.
- Supports ADD/SUB (SUB via b_inv plus carry_in), 1-bit right shift and 1-bit left shift through carry.
- Adds a small clocked flag register that accumulates carry, zero and negative status over a multi-nibble operation.

Parameters:
- NW, 4, data width in bits; only 4 is supported; elaboration error otherwise.

Ports:
- clk  input  1  system clock; used only by the flag register.
- rst  input  1  reset, asynchronous, active-high; clears the flag register.
- args  input  AluArgs (packed)  fields: ctrl.carry_in, ctrl.b_inv, ctrl.carry_disable, ctrl.cmd (AluCmd, 3 bits), d1[3:0], d2[3:0].
- flags_clr  input  1  starts a new accumulation; the first nibble of an operation.
- flags_we  input  1  captures the current nibble's status into the flags.
- ret  output  AluRet (packed)  fields: res[3:0], carry_out.
- flag_c  output  1  registered carry_out of the last captured nibble.
- flag_z  output  1  registered: all captured nibbles since the last flags_clr were zero.
- flag_n  output  1  registered res[3] of the last captured nibble.

Behaviour:
- ret is purely combinational, 0-cycle latency from args; no register is allowed in this path, because the caller samples it in the same cycle.
- Effective carry: cin = carry_disable ? 0 : carry_in.
- Effective operand: b = b_inv ? ~d2 : d2.
- ADD (cmd 0): {carry_out, res} = d1 + b + cin, 5-bit sum.
- RSHFT (cmd 1): res = {cin, d2[3:1]}; carry_out = d2[0]; d1 and b_inv are ignored. The caller walks nibbles MSB to LSB.
- LSHFT (cmd 2): res = {d2[2:0], cin}; carry_out = d2[3]; d1 and b_inv are ignored.
- carry_disable=1 additionally forces carry_out=0 for every cmd.
- Undefined or disabled cmd codes: res=0, carry_out=0.
- Flags:
  - on rst: flag_c=0, flag_z=1, flag_n=0.
  - at posedge clk with flags_we=1: flag_c<=carry_out; flag_n<=res[3]; flag_z<=(res==0) & (flags_clr ? 1 : flag_z).
  - flags_clr without flags_we: flag_z<=1, other flags hold.
  - neither asserted: all flags hold.
- Asserting rst mid-operation clears the flags immediately. ret is unaffected because it is combinational.
- X on any unused input field must not propagate to ret (e.g., d1=X with RSHFT still yields a defined res).

Optional Feature:
- Macro NIBBLE_ALU_LOGIC_OPS_EN.
- Defined: cmd 3=AND (res=d1&b), 4=OR (res=d1|b), 5=XOR (res=d1^b); carry_out=0 for all three; cin ignored.
- Undefined: cmd 3..5 behave as undefined codes (res=0, carry_out=0).

Decomposition:
- Package alu_pkg: enum AluCmd {ADD=0, RSHFT=1, LSHFT=2, AND=3, OR=4, XOR=5}; packed structs AluCtrl {carry_in, b_inv, carry_disable, cmd}, AluArgs {ctrl, d1, d2}, AluRet {res, carry_out}; localparam NIBBLE_W=4.
- Single module, no sub-module. The flag register is an always_ff block inside it.

Test Plan:
- ADD: d1=F, d2=1, cin=0 -> res=0, carry_out=1. Repeat with d1=E -> res=F, carry_out=0.
- SUB: d1=2, d2=3, b_inv=1, carry_in=1 -> res=F, carry_out=0. With d1=5, d2=3 -> res=2, carry_out=1.
- carry_disable: ADD d1=F, d2=0, carry_in=1, carry_disable=1 -> res=F, carry_out=0.
- RSHFT: d2=6, carry_in=0, d1=X -> res=3, carry_out=0. d2=1, carry_in=1 -> res=8, carry_out=1. LSHFT d2=9, carry_in=1 -> res=3, carry_out=1.
- Flags: rst pulse -> c=0, z=1, n=0. Nibbles 0,0,0 (first with flags_clr, all with flags_we) -> z=1. Next nibble 8 -> z=0, n=1. New flags_clr with nibble 0 -> z=1. Assert rst mid-sequence -> flags return to reset values asynchronously.
- Logic ops with NIBBLE_ALU_LOGIC_OPS_EN: d1=C, d2=A -> AND=8, OR=E, XOR=6, carry_out=0. Without the macro -> res=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the nibble ALU slice: command codes and packed bus payloads.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    RSHFT = 3'd1,
    LSHFT = 3'd2,
    AND   = 3'd3,
    OR    = 3'd4,
    XOR   = 3'd5
  } AluCmd;

  typedef struct packed {
    logic  carry_in;
    logic  b_inv;
    logic  carry_disable;
    AluCmd cmd;
  } AluCtrl;

  typedef struct packed {
    AluCtrl                ctrl;
    logic [NIBBLE_W-1:0]   d1;
    logic [NIBBLE_W-1:0]   d2;
  } AluArgs;

  typedef struct packed {
    logic [NIBBLE_W-1:0]   res;
    logic                  carry_out;
  } AluRet;

endpackage

// File: rtl/nibble_alu.sv
// Combinational 4-bit ALU slice with a clocked status-flag accumulator.
// Define NIBBLE_ALU_LOGIC_OPS_EN to enable the AND/OR/XOR commands.
module nibble_alu
  import alu_pkg::*;
#(
  parameter int unsigned NW = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  AluArgs args,
  input  logic   flags_clr,
  input  logic   flags_we,
  output AluRet  ret,
  output logic   flag_c,
  output logic   flag_z,
  output logic   flag_n
);

  if (NW != NIBBLE_W) begin : g_bad_nw
    $error("nibble_alu: only NW=4 is supported");
  end

  logic                cin;
  logic [NIBBLE_W-1:0] b;
  logic [NIBBLE_W:0]   sum;
  logic [NIBBLE_W-1:0] res;
  logic                cout;

  // Result path stays purely combinational; the caller samples it in the same cycle.
  always_comb begin
    cin  = args.ctrl.carry_disable ? 1'b0 : args.ctrl.carry_in;
    b    = args.ctrl.b_inv ? ~args.d2 : args.d2;
    sum  = (NIBBLE_W+1)'(args.d1) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(cin);
    res  = '0;
    cout = 1'b0;
    case (args.ctrl.cmd)
      ADD: begin
        res  = sum[NIBBLE_W-1:0];
        cout = sum[NIBBLE_W];
      end
      RSHFT: begin
        res  = {cin, args.d2[NIBBLE_W-1:1]};
        cout = args.d2[0];
      end
      LSHFT: begin
        res  = {args.d2[NIBBLE_W-2:0], cin};
        cout = args.d2[NIBBLE_W-1];
      end
`ifdef NIBBLE_ALU_LOGIC_OPS_EN
      AND: res = args.d1 & b;
      OR:  res = args.d1 | b;
      XOR: res = args.d1 ^ b;
`endif
      default: ;
    endcase
    ret.res       = res;
    ret.carry_out = cout & ~args.ctrl.carry_disable;
  end

  // Flags accumulate across the nibbles of one multi-nibble operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b1;
      flag_n <= 1'b0;
    end else if (flags_we) begin
      flag_c <= ret.carry_out;
      flag_n <= ret.res[NIBBLE_W-1];
      flag_z <= (ret.res == '0) & (flags_clr | flag_z);
    end else if (flags_clr) begin
      flag_z <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nibble_alu.sv
// Scoreboard bench for nibble_alu: stimulus queues expectations, a negedge monitor checks them.
module tb_nibble_alu;
  import alu_pkg::*;

  typedef struct {
    string      name;
    logic [3:0] res;
    logic       co;
  } ret_exp_t;

  typedef struct {
    string name;
    logic  c;
    logic  z;
    logic  n;
  } flg_exp_t;

  logic   clk = 1'b0;
  logic   rst;
  AluArgs args;
  logic   flags_clr;
  logic   flags_we;
  AluRet  ret;
  logic   flag_c, flag_z, flag_n;

  logic   vld;
  logic   chk_flg;
  int     checks = 0;
  int     failures = 0;

  ret_exp_t q_ret[$];
  flg_exp_t q_flg[$];

  nibble_alu #(.NW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .args      (args),
    .flags_clr (flags_clr),
    .flags_we  (flags_we),
    .ret       (ret),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  always #5 clk = ~clk;

  // Monitor: pops and compares whenever a result or flag check is presented.
  always @(negedge clk) begin
    ret_exp_t er;
    flg_exp_t ef;
    if (vld) begin
      checks++;
      if (q_ret.size() == 0) begin
        failures++;
        $display("FAIL ret_underflow: result presented with no expectation queued");
      end else begin
        er = q_ret.pop_front();
        if (ret.res !== er.res || ret.carry_out !== er.co) begin
          failures++;
          $display("FAIL %s: got res=%h co=%b, expected res=%h co=%b",
                   er.name, ret.res, ret.carry_out, er.res, er.co);
        end
      end
    end
    if (chk_flg) begin
      checks++;
      if (q_flg.size() == 0) begin
        failures++;
        $display("FAIL flg_underflow: flag check with no expectation queued");
      end else begin
        ef = q_flg.pop_front();
        if (flag_c !== ef.c || flag_z !== ef.z || flag_n !== ef.n) begin
          failures++;
          $display("FAIL %s: got c=%b z=%b n=%b, expected c=%b z=%b n=%b",
                   ef.name, flag_c, flag_z, flag_n, ef.c, ef.z, ef.n);
        end
      end
    end
  end

  // One cycle of ALU stimulus with its expected combinational result.
  task automatic drive(input string name, input AluCmd cmd, input logic cin,
                       input logic binv, input logic cdis, input logic [3:0] d1,
                       input logic [3:0] d2, input logic clr, input logic we,
                       input logic [3:0] exp_res, input logic exp_co);
    ret_exp_t e;
    args.ctrl.cmd           = cmd;
    args.ctrl.carry_in      = cin;
    args.ctrl.b_inv         = binv;
    args.ctrl.carry_disable = cdis;
    args.d1                 = d1;
    args.d2                 = d2;
    flags_clr               = clr;
    flags_we                = we;
    chk_flg                 = 1'b0;
    vld                     = 1'b1;
    e.name = name; e.res = exp_res; e.co = exp_co;
    q_ret.push_back(e);
    @(posedge clk); #1;
  endtask

  // One idle cycle checking the registered flags.
  task automatic expect_flags(input string name, input logic c, input logic z, input logic n);
    flg_exp_t e;
    vld       = 1'b0;
    flags_we  = 1'b0;
    flags_clr = 1'b0;
    chk_flg   = 1'b1;
    e.name = name; e.c = c; e.z = z; e.n = n;
    q_flg.push_back(e);
    @(posedge clk); #1;
    chk_flg   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flg_exp_t ef;
    logic [3:0] xn;
    rst = 1'b1; args = '0; flags_clr = 1'b0; flags_we = 1'b0; vld = 1'b0; chk_flg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_flags("rst_hold", 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    expect_flags("rst_release", 1'b0, 1'b1, 1'b0);

    // Arithmetic
    drive("add_f_1",   ADD, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1);
    drive("add_e_1",   ADD, 1'b0, 1'b0, 1'b0, 4'hE, 4'h1, 1'b0, 1'b0, 4'hF, 1'b0);
    drive("sub_2_3",   ADD, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3, 1'b0, 1'b0, 4'hF, 1'b0);
    drive("sub_5_3",   ADD, 1'b1, 1'b1, 1'b0, 4'h5, 4'h3, 1'b0, 1'b0, 4'h2, 1'b1);
    drive("cdis_f_0",  ADD, 1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0);
    drive("cdis_f_1",  ADD, 1'b0, 1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);

    // Shifts, with d1 left undefined
    xn = 'x;
    drive("rsh_6",     RSHFT, 1'b0, 1'b0, 1'b0, xn, 4'h6, 1'b0, 1'b0, 4'h3, 1'b0);
    drive("rsh_1_c1",  RSHFT, 1'b1, 1'b0, 1'b0, xn, 4'h1, 1'b0, 1'b0, 4'h8, 1'b1);
    drive("rsh_binv",  RSHFT, 1'b0, 1'b1, 1'b0, 4'hA, 4'h6, 1'b0, 1'b0, 4'h3, 1'b0);
    drive("lsh_9_c1",  LSHFT, 1'b1, 1'b0, 1'b0, xn, 4'h9, 1'b0, 1'b0, 4'h3, 1'b1);
    drive("lsh_cdis",  LSHFT, 1'b1, 1'b0, 1'b1, xn, 4'h9, 1'b0, 1'b0, 4'h2, 1'b0);

    // Logic ops and undefined codes
`ifdef NIBBLE_ALU_LOGIC_OPS_EN
    drive("and_c_a",   AND, 1'b1, 1'b0, 1'b0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 1'b0);
    drive("or_c_a",    OR,  1'b1, 1'b0, 1'b0, 4'hC, 4'hA, 1'b0, 1'b0, 4'hE, 1'b0);
    drive("xor_c_a",   XOR, 1'b1, 1'b0, 1'b0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h6, 1'b0);
`else
    drive("and_off",   AND, 1'b1, 1'b0, 1'b0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0);
    drive("or_off",    OR,  1'b1, 1'b0, 1'b0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0);
    drive("xor_off",   XOR, 1'b1, 1'b0, 1'b0, 4'hC, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0);
`endif
    drive("cmd6",      AluCmd'(3'd6), 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
    drive("cmd7",      AluCmd'(3'd7), 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);

    // Flag accumulation over a multi-nibble operation
    drive("z_nib0",    ADD, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0);
    drive("z_nib1",    ADD, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0);
    drive("z_nib2",    ADD, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0);
    expect_flags("flags_all_zero", 1'b0, 1'b1, 1'b0);
    drive("n_nib8",    ADD, 1'b0, 1'b0, 1'b0, 4'h8, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0);
    expect_flags("flags_nib8", 1'b0, 1'b0, 1'b1);
    drive("c_nib",     ADD, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1);
    expect_flags("flags_z_sticky", 1'b1, 1'b0, 1'b0);
    drive("clr_nib0",  ADD, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0);
    expect_flags("flags_new_op", 1'b0, 1'b1, 1'b0);
    drive("pre_clr8",  ADD, 1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 1'b0, 1'b1, 4'h9, 1'b0);
    drive("clr_only",  ADD, 1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 1'b0, 4'h2, 1'b0);
    expect_flags("flags_clr_only", 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-operation; ret must stay valid meanwhile
    drive("mid_c",     ADD, 1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 1'b1, 1'b1, 4'h0, 1'b1);
    drive("mid_8",     ADD, 1'b0, 1'b0, 1'b0, 4'h8, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0);
    args.ctrl.cmd = ADD; args.ctrl.carry_in = 1'b0; args.ctrl.b_inv = 1'b0;
    args.ctrl.carry_disable = 1'b0; args.d1 = 4'h3; args.d2 = 4'h4;
    flags_clr = 1'b0; flags_we = 1'b1; vld = 1'b1; chk_flg = 1'b1;
    q_ret.push_back('{name: "ret_in_rst", res: 4'h7, co: 1'b0});
    ef.name = "flags_async_rst"; ef.c = 1'b0; ef.z = 1'b1; ef.n = 1'b0;
    q_flg.push_back(ef);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; chk_flg = 1'b0;
    rst = 1'b0;
    expect_flags("flags_after_rst", 1'b0, 1'b1, 1'b0);

    vld = 1'b0; chk_flg = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (q_ret.size() != 0 || q_flg.size() != 0) begin
      failures++;
      $display("FAIL drain: ret_left=%0d flg_left=%0d expected 0", q_ret.size(), q_flg.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
